// File: rtl/l0mdt_dataformats_svh.sv
// +--------------------------------------------------------------------------+
// | Package : l0mdt_dataformats_svh                                          |
// | Shared L0MDT data-format constants and types used by the pT-calc to MTC  |
// | scheduler and its per-thread FIFOs.                                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package l0mdt_dataformats_svh;

  // Width of one pT-calc result word sent towards the MTC builder
  localparam int PTCALC2MTC_LEN = 32;
  typedef logic [PTCALC2MTC_LEN-1:0] ptcalc2mtc_rvt;

  // Default number of words buffered per pT-calc thread
  localparam int MTC_SCHED_FIFO_DEPTH = 4;

  // Output register occupancy
  typedef enum logic [0:0] {
    SCHED_EMPTY  = 1'b0,
    SCHED_LOADED = 1'b1
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/mtc_sched_fifo.sv
// +--------------------------------------------------------------------------+
// | Module  : mtc_sched_fifo                                                 |
// | Small synchronous FIFO for one pT-calc thread. A push into a full FIFO   |
// | succeeds when a pop happens in the same cycle.                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module mtc_sched_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush wins over any push/pop
  always_comb begin
    do_pop   = pop & ~empty & ~srst;
    do_push  = push & (~full | do_pop) & ~srst;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (srst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer/occupancy registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/mtc_ptcalc_scheduler.sv
// +--------------------------------------------------------------------------+
// | Module  : mtc_ptcalc_scheduler                                           |
// | Shares one MTC-builder input lane between c_NUM_THREADS pT-calc threads: |
// | per-thread FIFOs, round-robin arbiter, registered valid/ready output and |
// | per-thread overflow (drop) pulses.                                       |
// | Option  : MTC_SCHED_DROPCNT_EN adds saturating 16-bit drop counters.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module mtc_ptcalc_scheduler
  import l0mdt_dataformats_svh::*;
#(
  parameter int PTCALC_WIDTH  = PTCALC2MTC_LEN,
  parameter int c_NUM_THREADS = 3,
  parameter int FIFO_DEPTH    = MTC_SCHED_FIFO_DEPTH,
  localparam int THR_W        = (c_NUM_THREADS > 1) ? $clog2(c_NUM_THREADS) : 1
) (
  input  logic                                clock,
  input  logic                                rst_n,
  input  logic                                srst,
  input  logic [PTCALC_WIDTH*c_NUM_THREADS-1:0] ptcalc,
  input  logic [c_NUM_THREADS-1:0]            ptcalc_vld,
  output logic [c_NUM_THREADS-1:0]            ptcalc_rdy,
  output logic [PTCALC_WIDTH-1:0]             out_data,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic [THR_W-1:0]                    out_thread,
  output logic [c_NUM_THREADS-1:0]            drop
`ifdef MTC_SCHED_DROPCNT_EN
  ,
  output logic [16*c_NUM_THREADS-1:0]         drop_cnt
`endif
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [THR_W:0]   NT       = (THR_W+1)'(c_NUM_THREADS);

  logic [PTCALC_WIDTH-1:0]              fifo_data [c_NUM_THREADS];
  logic [c_NUM_THREADS-1:0]             fifo_full, fifo_empty, fifo_pop;
  logic [c_NUM_THREADS-1:0][CW-1:0]     fifo_count;

  sched_state_e                 state_q, state_d;
  logic [PTCALC_WIDTH-1:0]      out_data_q, out_data_d;
  logic [THR_W-1:0]             out_thread_q, out_thread_d;
  logic [THR_W-1:0]             rr_q, rr_d;
  logic [c_NUM_THREADS-1:0]     drop_q, drop_d;

  logic [2*c_NUM_THREADS-1:0]   req_dbl;
  logic [c_NUM_THREADS-1:0]     req_rot;
  logic [THR_W:0]               grant_sum;
  logic [THR_W:0]               rr_nxt;
  logic [THR_W-1:0]             grant_idx;
  logic                         grant_vld;
  logic                         take;

  // One FIFO per thread; ready is derived from occupancy so it is all-1 right after reset
  for (genvar i = 0; i < c_NUM_THREADS; i++) begin : g_fifo
    mtc_sched_fifo #(
      .WIDTH (PTCALC_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .rst_n     (rst_n),
      .srst      (srst),
      .push      (ptcalc_vld[i]),
      .push_data (ptcalc[i*PTCALC_WIDTH +: PTCALC_WIDTH]),
      .pop       (fifo_pop[i]),
      .pop_data  (fifo_data[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .count     (fifo_count[i])
    );
    assign ptcalc_rdy[i] = (fifo_count[i] != FULL_CNT);
  end

  // Round-robin pick: rotate requests so the rr pointer sits at bit 0, take the first set bit
  always_comb begin
    req_dbl   = {~fifo_empty, ~fifo_empty};
    req_rot   = c_NUM_THREADS'(req_dbl >> rr_q);
    grant_vld = 1'b0;
    grant_sum = '0;
    for (int k = 0; k < c_NUM_THREADS; k++) begin
      if (!grant_vld && req_rot[k]) begin
        grant_vld = 1'b1;
        grant_sum = {1'b0, rr_q} + (THR_W+1)'(k);
      end
    end
    grant_idx = (grant_sum >= NT) ? THR_W'(grant_sum - NT) : THR_W'(grant_sum);
    rr_nxt    = {1'b0, grant_idx} + (THR_W+1)'(1);
  end

  // Output register next-state: load when empty or when the current word is accepted
  always_comb begin
    take         = grant_vld & ~srst & ((state_q == SCHED_EMPTY) | out_rdy);
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_thread_d = out_thread_q;
    rr_d         = rr_q;
    for (int i = 0; i < c_NUM_THREADS; i++) begin
      fifo_pop[i] = take && (grant_idx == THR_W'(i));
    end
    if (srst) begin
      state_d      = SCHED_EMPTY;
      out_data_d   = '0;
      out_thread_d = '0;
      rr_d         = '0;
    end else if ((state_q == SCHED_EMPTY) || out_rdy) begin
      if (grant_vld) begin
        state_d      = SCHED_LOADED;
        out_data_d   = fifo_data[grant_idx];
        out_thread_d = grant_idx;
        rr_d         = (rr_nxt >= NT) ? '0 : THR_W'(rr_nxt);
      end else begin
        state_d = SCHED_EMPTY;
      end
    end
    // A write into a full FIFO is lost unless that FIFO is popped in the same cycle
    drop_d = {c_NUM_THREADS{~srst}} & ptcalc_vld & fifo_full & ~fifo_pop;
  end

  // Output register, arbitration pointer and drop pulse registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SCHED_EMPTY;
      out_data_q   <= '0;
      out_thread_q <= '0;
      rr_q         <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_thread_q <= out_thread_d;
      rr_q         <= rr_d;
      drop_q       <= drop_d;
    end
  end

  assign out_vld    = (state_q == SCHED_LOADED);
  assign out_data   = out_data_q;
  assign out_thread = out_thread_q;
  assign drop       = drop_q;

`ifdef MTC_SCHED_DROPCNT_EN
  logic [c_NUM_THREADS-1:0][15:0] drop_cnt_q, drop_cnt_d;

  // Saturating per-thread drop counters, advanced together with the drop pulse
  always_comb begin
    for (int i = 0; i < c_NUM_THREADS; i++) begin
      drop_cnt_d[i] = drop_cnt_q[i];
      if (srst) begin
        drop_cnt_d[i] = '0;
      end else if (drop_d[i] && (drop_cnt_q[i] != 16'hFFFF)) begin
        drop_cnt_d[i] = drop_cnt_q[i] + 16'd1;
      end
    end
  end

  // Drop counter registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire
